// File: rtl/aes_stream_host.sv
// Byte-serial host driver for the AES-128 core: latches a key/block, resets and
// loads the core MSB first, then reassembles its 16 output bytes LSB first.
module aes_stream_host #(
  parameter int TIMEOUT      = 1024,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [127:0] block_in,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [127:0] result,
  output logic         core_rst,
  output logic         core_enable,
  output logic [7:0]   key_byte,
  output logic [7:0]   state_byte,
  input  logic         core_ready,
  input  logic [7:0]   core_out_byte
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(CLEAR_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_WAIT,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  clr_cnt, clr_cnt_n;
  logic [3:0]     byte_idx, byte_idx_n;
  logic [TW-1:0]  tmo_cnt, tmo_cnt_n;
  logic [3:0]     col_cnt, col_cnt_n;
  logic [127:0]   key_reg, key_reg_n;
  logic [127:0]   blk_reg, blk_reg_n;
  logic [127:0]   result_n;
  logic           error_n, done_n, busy_n;
  logic           core_rst_n, core_enable_n;
  logic [7:0]     key_byte_n, state_byte_n;

  // Every output is computed from the next state here and registered below, so
  // the core sees glitch-free, flop-driven controls.
  always_comb begin
    state_n       = state;
    clr_cnt_n     = clr_cnt;
    byte_idx_n    = byte_idx;
    tmo_cnt_n     = tmo_cnt;
    col_cnt_n     = col_cnt;
    key_reg_n     = key_reg;
    blk_reg_n     = blk_reg;
    result_n      = result;
    error_n       = error;
    key_byte_n    = 8'h00;
    state_byte_n  = 8'h00;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n   = S_CLEAR;
          key_reg_n = key_in;
          blk_reg_n = block_in;
          error_n   = 1'b0;
          result_n  = '0;
          clr_cnt_n = '0;
        end
      end

      S_CLEAR: begin
        if (clr_cnt == CW'(CLEAR_CYCLES - 1)) begin
          state_n      = S_LOAD;
          byte_idx_n   = 4'd0;
          key_byte_n   = key_reg[127:120];
          state_byte_n = blk_reg[127:120];
          key_reg_n    = key_reg << 8;
          blk_reg_n    = blk_reg << 8;
        end else begin
          clr_cnt_n = clr_cnt + 1'b1;
        end
      end

      // key_reg/blk_reg shift left as bytes go out, so the top byte is always next.
      S_LOAD: begin
        if (byte_idx == 4'd15) begin
          state_n   = S_WAIT;
          tmo_cnt_n = '0;
        end else begin
          byte_idx_n   = byte_idx + 4'd1;
          key_byte_n   = key_reg[127:120];
          state_byte_n = blk_reg[127:120];
          key_reg_n    = key_reg << 8;
          blk_reg_n    = blk_reg << 8;
        end
      end

      S_WAIT: begin
        if (core_ready) begin
          result_n[7:0] = core_out_byte;
          col_cnt_n     = 4'd1;
          state_n       = S_COLLECT;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          error_n = 1'b1;
          state_n = S_DONE;
        end else begin
          tmo_cnt_n = tmo_cnt + 1'b1;
        end
      end

      // A gap in core_ready ends the burst early; bytes already captured are kept.
      S_COLLECT: begin
        if (core_ready) begin
          result_n[{col_cnt, 3'b000} +: 8] = core_out_byte;
          if (col_cnt == 4'd15) begin
            state_n = S_DONE;
          end else begin
            col_cnt_n = col_cnt + 4'd1;
          end
        end else begin
          error_n = 1'b1;
          state_n = S_DONE;
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    busy_n        = (state_n != S_IDLE);
    done_n        = (state_n == S_DONE);
    core_rst_n    = (state_n inside {S_IDLE, S_CLEAR, S_DONE});
    core_enable_n = (state_n inside {S_LOAD, S_WAIT, S_COLLECT});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      clr_cnt     <= '0;
      byte_idx    <= '0;
      tmo_cnt     <= '0;
      col_cnt     <= '0;
      key_reg     <= '0;
      blk_reg     <= '0;
      result      <= '0;
      error       <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      core_rst    <= 1'b1;
      core_enable <= 1'b0;
      key_byte    <= 8'h00;
      state_byte  <= 8'h00;
    end else begin
      state       <= state_n;
      clr_cnt     <= clr_cnt_n;
      byte_idx    <= byte_idx_n;
      tmo_cnt     <= tmo_cnt_n;
      col_cnt     <= col_cnt_n;
      key_reg     <= key_reg_n;
      blk_reg     <= blk_reg_n;
      result      <= result_n;
      error       <= error_n;
      done        <= done_n;
      busy        <= busy_n;
      core_rst    <= core_rst_n;
      core_enable <= core_enable_n;
      key_byte    <= key_byte_n;
      state_byte  <= state_byte_n;
    end
  end

endmodule
